// File: rtl/demux2_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux2_reg_if                                                 |
// | Description : Producer and dual-consumer handshake bundle for demux2_reg;   |
// |               cnt_a/cnt_b exist only when DEMUX_CNT_EN is defined.           |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface demux2_reg_if #(
    parameter int W     = 8
`ifdef DEMUX_CNT_EN
   ,parameter int CNT_W = 8
`endif
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         sel;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_data;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] b_data;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
`endif

    modport master (
        output in_valid, in_data, sel, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data
`ifdef DEMUX_CNT_EN
       ,input  cnt_a, cnt_b
`endif
    );

    modport slave (
        input  in_valid, in_data, sel, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data
`ifdef DEMUX_CNT_EN
       ,output cnt_a, cnt_b
`endif
    );
endinterface
`default_nettype wire

// File: rtl/demux2_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux2_reg                                                    |
// | Description : Registered 1:2 demux, sel=1 -> A, sel=0 -> B, one-entry       |
// |               output register per channel. DEMUX_CNT_EN adds saturating     |
// |               per-channel delivered-word counters.                          |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module demux2_reg #(
    parameter int W     = 8
`ifdef DEMUX_CNT_EN
   ,parameter int CNT_W = 8
`endif
) (
    input wire logic    clk,
    input wire logic    rst_n,
    demux2_reg_if.slave bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t       r_state_a;
    state_t       r_state_b;
    state_t       w_next_a;
    state_t       w_next_b;
    logic [W-1:0] r_a_data;
    logic [W-1:0] r_b_data;
    logic         w_in_ready;
    logic         w_load_a;
    logic         w_load_b;

    // A full channel can still accept when its consumer drains in the same cycle.
    always_comb begin
        w_in_ready = 1'b0;
        w_load_a   = 1'b0;
        w_load_b   = 1'b0;
        if (bus.sel) begin
            w_in_ready = rst_n & ((r_state_a == ST_EMPTY) | bus.a_ready);
        end else begin
            w_in_ready = rst_n & ((r_state_b == ST_EMPTY) | bus.b_ready);
        end
        w_load_a = bus.in_valid & w_in_ready & bus.sel;
        w_load_b = bus.in_valid & w_in_ready & ~bus.sel;
    end

    always_comb begin
        w_next_a = r_state_a;
        w_next_b = r_state_b;
        case (r_state_a)
            ST_EMPTY: if (w_load_a) w_next_a = ST_FULL;
            ST_FULL:  if (bus.a_ready && !w_load_a) w_next_a = ST_EMPTY;
            default:  w_next_a = ST_EMPTY;
        endcase
        case (r_state_b)
            ST_EMPTY: if (w_load_b) w_next_b = ST_FULL;
            ST_FULL:  if (bus.b_ready && !w_load_b) w_next_b = ST_EMPTY;
            default:  w_next_b = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_a <= ST_EMPTY;
            r_state_b <= ST_EMPTY;
            r_a_data  <= '0;
            r_b_data  <= '0;
        end else begin
            r_state_a <= w_next_a;
            r_state_b <= w_next_b;
            if (w_load_a) r_a_data <= bus.in_data;
            if (w_load_b) r_b_data <= bus.in_data;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.a_valid  = (r_state_a == ST_FULL);
    assign bus.b_valid  = (r_state_b == ST_FULL);
    assign bus.a_data   = r_a_data;
    assign bus.b_data   = r_b_data;

`ifdef DEMUX_CNT_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if ((r_state_a == ST_FULL) && bus.a_ready && (r_cnt_a != C_CNT_MAX))
                r_cnt_a <= r_cnt_a + 1'b1;
            if ((r_state_b == ST_FULL) && bus.b_ready && (r_cnt_b != C_CNT_MAX))
                r_cnt_b <= r_cnt_b + 1'b1;
        end
    end

    assign bus.cnt_a = r_cnt_a;
    assign bus.cnt_b = r_cnt_b;
`endif

endmodule
`default_nettype wire
